// File: rtl/gpio_debounce_ctrl.sv
// Push-button conditioning: 2-FF sync and debounce per channel, fixed-priority
// edge-event arbiter feeding a small valid/ready event FIFO with sticky overflow.
module gpio_debounce_ctrl #(
    parameter int unsigned NumIn          = 3,
    parameter int unsigned DebounceCycles = 60000,
    parameter int unsigned CntWidth       = 16,
    parameter int unsigned FifoDepth      = 4,
    localparam int unsigned IdW           = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NumIn-1:0] pin_i,
    output logic [NumIn-1:0] level_o,
    output logic             event_valid_o,
    input  logic             event_ready_i,
    output logic [IdW-1:0]   event_id_o,
    output logic             event_rise_o,
    output logic             overflow_o,
    input  logic             overflow_clr_i
);

    localparam int unsigned        PtrW    = $clog2(FifoDepth);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DebounceCycles - 1);
    localparam logic [PtrW:0]       FullCnt = (PtrW + 1)'(FifoDepth);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } deb_state_e;

    logic [NumIn-1:0]    r_sync1;
    logic [NumIn-1:0]    r_sync2;
    logic [NumIn-1:0]    r_level;
    logic [NumIn-1:0]    r_pend;
    logic [NumIn-1:0]    r_edge;
    deb_state_e          r_state [NumIn];
    logic [CntWidth-1:0] r_cnt   [NumIn];
    logic                r_overflow;

    deb_state_e          w_state_nxt [NumIn];
    logic [CntWidth-1:0] w_cnt_nxt   [NumIn];
    logic [NumIn-1:0]    w_toggle;

    logic [IdW-1:0]      r_mem_id   [FifoDepth];
    logic                r_mem_rise [FifoDepth];
    logic [PtrW:0]       r_wptr;
    logic [PtrW:0]       r_rptr;

    logic [PtrW:0]       w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic [NumIn-1:0]    w_push_oh;
    logic [IdW-1:0]      w_push_idx;
    logic                w_push_rise;
    logic                w_ovf_set;

    // Debounce FSM: counts consecutive cycles the synchronised pin differs from level.
    always_comb begin
        for (int unsigned i = 0; i < NumIn; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = '0;
            w_toggle[i]    = 1'b0;
            case (r_state[i])
                ST_STABLE: begin
                    if (r_sync2[i] != r_level[i]) begin
                        w_state_nxt[i] = ST_CHECK;
                        w_cnt_nxt[i]   = CntWidth'(1);
                    end
                end
                ST_CHECK: begin
                    if (r_sync2[i] == r_level[i]) begin
                        w_state_nxt[i] = ST_STABLE;
                    end else if (r_cnt[i] == CntLast) begin
                        w_state_nxt[i] = ST_STABLE;
                        w_toggle[i]    = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CntWidth'(1);
                    end
                end
                default: w_state_nxt[i] = ST_STABLE;
            endcase
        end
    end

    assign w_count = r_wptr - r_rptr;
    assign w_full  = (w_count == FullCnt);
    assign w_empty = (r_wptr == r_rptr);
    assign w_pop   = ~w_empty & event_ready_i;

    // Lowest pending index wins; fullness is judged before any pop this cycle.
    always_comb begin
        w_push_oh  = '0;
        w_push_idx = '0;
        w_push     = 1'b0;
        if (!w_full) begin
            for (int unsigned i = 0; i < NumIn; i++) begin
                if (r_pend[i] && !w_push) begin
                    w_push       = 1'b1;
                    w_push_oh[i] = 1'b1;
                    w_push_idx   = IdW'(i);
                end
            end
        end
    end

    assign w_push_rise = |(r_edge & w_push_oh);
    assign w_ovf_set   = |(w_toggle & r_pend & ~w_push_oh);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_level    <= '0;
            r_pend     <= '0;
            r_edge     <= '0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < NumIn; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1 <= pin_i;
            r_sync2 <= r_sync1;
            r_level <= r_level ^ w_toggle;
            // A toggle on the push cycle re-arms pend with the new edge.
            r_pend  <= (r_pend & ~w_push_oh) | w_toggle;
            r_edge  <= (r_edge & ~w_toggle) | (~r_level & w_toggle);
            for (int unsigned i = 0; i < NumIn; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int unsigned k = 0; k < FifoDepth; k++) begin
                r_mem_id[k]   <= '0;
                r_mem_rise[k] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_id[r_wptr[PtrW-1:0]]   <= w_push_idx;
                r_mem_rise[r_wptr[PtrW-1:0]] <= w_push_rise;
                r_wptr                       <= r_wptr + (PtrW + 1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (PtrW + 1)'(1);
            end
        end
    end

    assign level_o       = r_level;
    assign event_valid_o = ~w_empty;
    assign event_id_o    = r_mem_id[r_rptr[PtrW-1:0]];
    assign event_rise_o  = r_mem_rise[r_rptr[PtrW-1:0]];
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_gpio_debounce_ctrl.sv
// Bench for gpio_debounce_ctrl: run-length debounce model, event queue model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gpio_debounce_ctrl;

    localparam int NI = 3;
    localparam int DB = 8;
    localparam int FD = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] pin   = '0;
    logic          ready = 1'b0;
    logic          clr   = 1'b0;
    logic [NI-1:0] level;
    logic          valid;
    logic          rise;
    logic          ovf;
    logic [1:0]    id;

    gpio_debounce_ctrl #(
        .NumIn(NI),
        .DebounceCycles(DB),
        .CntWidth(4),
        .FifoDepth(FD)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .pin_i(pin),
        .level_o(level),
        .event_valid_o(valid),
        .event_ready_i(ready),
        .event_id_o(id),
        .event_rise_o(rise),
        .overflow_o(ovf),
        .overflow_clr_i(clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pin must differ from its accepted level for DB consecutive
    // synchronised samples; each accepted change is one event.
    int m_sy1 [NI];
    int m_sy2 [NI];
    int m_lvl [NI];
    int m_run [NI];
    int m_pend[NI];
    int m_edge[NI];
    int m_ovf;
    int mq[$];

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_sy1[i] = 0; m_sy2[i] = 0; m_lvl[i] = 0;
            m_run[i] = 0; m_pend[i] = 0; m_edge[i] = 0;
        end
        m_ovf = 0;
        mq.delete();
    endfunction

    function automatic void model_step();
        int p;
        int set;
        p   = -1;
        set = 0;
        if (mq.size() < FD)
            for (int i = 0; i < NI; i++)
                if (m_pend[i] != 0 && p < 0) p = i;
        if (mq.size() > 0 && ready) mq.delete(0);
        if (p >= 0) begin
            mq.push_back(p * 2 + m_edge[p]);
            m_pend[p] = 0;
        end
        for (int i = 0; i < NI; i++) begin
            if (m_sy2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_run[i]  = 0;
                    m_lvl[i]  = 1 - m_lvl[i];
                    if (m_pend[i] != 0) set = 1;
                    m_pend[i] = 1;
                    m_edge[i] = m_lvl[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (set != 0) m_ovf = 1;
        else if (clr) m_ovf = 0;
        for (int i = 0; i < NI; i++) begin
            m_sy2[i] = m_sy1[i];
            m_sy1[i] = int'(pin[i]);
        end
    endfunction

    function automatic int m_level_vec();
        int v;
        v = 0;
        for (int i = 0; i < NI; i++) v = v | (m_lvl[i] << i);
        return v;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level", 32'(level), 32'(m_level_vec()));
            chk("valid", 32'(valid), 32'(mq.size() > 0));
            chk("overflow", 32'(ovf), 32'(m_ovf));
            if (mq.size() > 0) begin
                chk("head_id", 32'(id), 32'(mq[0] >> 1));
                chk("head_rise", 32'(rise), 32'(mq[0] & 1));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int got_id[$];
    int got_rise[$];
    int got_cyc[$];

    task automatic collect(input int ncyc);
        got_id.delete(); got_rise.delete(); got_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (valid === 1'b1 && ready === 1'b1) begin
                got_id.push_back(int'(id));
                got_rise.push_back(int'(rise));
                got_cyc.push_back(c);
            end
        end
        #1;
    endtask

    task automatic press(input int ch, input logic val);
        pin[ch] = val;
        tick(12);
    endtask

    int exp_id[5]   = '{0, 1, 0, 1, 0};
    int exp_rise[5] = '{1, 1, 0, 0, 0};
    int mode;
    int ch;

    initial begin
        // Reset and mid-count reset
        tick(1);
        chk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_id", 32'(id), 0);
        chk("rst_rise", 32'(rise), 0);
        chk("rst_ovf", 32'(ovf), 0);
        pin[0] = 1'b1;
        tick(11);
        chk("pre_rst_level", 32'(level), 1);
        chk("pre_rst_valid", 32'(valid), 1);
        pin[0] = 1'b0;
        tick(5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_level", 32'(level), 0);
        chk("async_valid", 32'(valid), 0);
        chk("async_id", 32'(id), 0);
        chk("async_rise", 32'(rise), 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("post_rst_valid", 32'(valid), 0);

        // Clean press: level on the 10th edge, event one edge later
        pin[0] = 1'b1;
        tick(9);
        chk("press_edge9", 32'(level[0]), 0);
        tick(1);
        chk("press_edge10", 32'(level[0]), 1);
        tick(1);
        chk("press_valid", 32'(valid), 1);
        chk("press_id", 32'(id), 0);
        chk("press_rise", 32'(rise), 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("press_popped", 32'(valid), 0);
        pin[0] = 1'b0;
        tick(11);
        chk("release_valid", 32'(valid), 1);
        chk("release_id", 32'(id), 0);
        chk("release_rise", 32'(rise), 0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;

        // Bounce rejection
        pin[1] = 1'b1;
        tick(5);
        pin[1] = 1'b0;
        tick(15);
        chk("bounce_level", 32'(level), 0);
        chk("bounce_valid", 32'(valid), 0);
        chk("bounce_ovf", 32'(ovf), 0);

        // Simultaneous rise on all channels
        pin   = 3'b111;
        ready = 1'b1;
        collect(30);
        chk("simul_count", 32'(got_id.size()), 3);
        for (int k = 0; k < got_id.size() && k < 3; k++) begin
            chk("simul_id", 32'(got_id[k]), 32'(k));
            chk("simul_rise", 32'(got_rise[k]), 1);
            if (k > 0) chk("simul_consec", 32'(got_cyc[k] - got_cyc[k-1]), 1);
        end
        pin = 3'b000;
        tick(30);
        ready = 1'b0;

        // Backpressure, pending hold, overwrite, clear, ordered drain
        press(0, 1'b1);
        press(1, 1'b1);
        press(0, 1'b0);
        press(1, 1'b0);
        press(0, 1'b1);
        chk("full_valid", 32'(valid), 1);
        chk("full_no_ovf", 32'(ovf), 0);
        press(0, 1'b0);
        chk("overwrite_ovf", 32'(ovf), 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);
        ready = 1'b1;
        collect(20);
        chk("drain_count", 32'(got_id.size()), 5);
        for (int k = 0; k < got_id.size() && k < 5; k++) begin
            chk("drain_id", 32'(got_id[k]), 32'(exp_id[k]));
            chk("drain_rise", 32'(got_rise[k]), 32'(exp_rise[k]));
        end
        ready = 1'b0;

        // Clear/set race: set must win
        press(2, 1'b1);
        press(2, 1'b0);
        press(2, 1'b1);
        press(2, 1'b0);
        press(2, 1'b1);
        chk("race_pre_ovf", 32'(ovf), 0);
        pin[2] = 1'b0;
        tick(9);
        clr = 1'b1;
        tick(1);
        chk("race_set_wins", 32'(ovf), 1);
        tick(1);
        clr = 1'b0;
        chk("race_then_clear", 32'(ovf), 0);
        ready = 1'b1;
        tick(20);

        // Randomized traffic
        mode = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                ch = int'($urandom_range(0, NI - 1));
                pin[ch] = ~pin[ch];
            end
            ready = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 39) == 0);
            if (c == 2000) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            tick(1);
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_debounce_ctrl.md
Name: gpio_debounce_ctrl

Overview:
- Input-conditioning and event scheduler between the board push-buttons and the SoC GPIO input bus.
- Per channel: synchronises the raw pin, debounces it, and presents a stable level.
- Arbitrates per-channel edge events into a small event FIFO with a valid/ready interface. Software or the GPIO block drains one event per handshake.
- Runs in the SoC clock domain (6 MHz on the FPGA build).

Parameters:
- NumIn, 3, number of input channels (1..16).
- DebounceCycles, 60000, clock cycles an input must hold a new value before it is accepted (>= 2; 10 ms at 6 MHz).
- CntWidth, 16, debounce counter width; must satisfy 2**CntWidth > DebounceCycles.
- FifoDepth, 4, event FIFO entries (power of 2, >= 2).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- pin_i  input  NumIn  raw asynchronous button inputs.
- level_o  output  NumIn  debounced level per channel.
- event_valid_o  output  1  FIFO non-empty.
- event_ready_i  input  1  consumer accepts the head event.
- event_id_o  output  $clog2(NumIn) (min 1)  channel index of the head event.
- event_rise_o  output  1  1 = rising edge, 0 = falling edge.
- overflow_o  output  1  sticky flag: an event was lost.
- overflow_clr_i  input  1  clears overflow_o.

Behaviour:
- Reset (async, rst_ni=0):
  - Sync flops, level_o, counters, pending bits, FIFO pointers and overflow_o all clear to 0.
  - Consequently event_valid_o=0, event_id_o=0 and event_rise_o=0.
  - Any in-flight debounce is discarded.
  - A pin held at 1 through reset yields a normal rise event once debounced after release.
- Sync: 2-FF synchroniser per channel, producing s[i].
- Per-channel FSM, two states:
  - STABLE: if s[i] != level_o[i], go to CHECK with cnt=1; otherwise cnt=0.
  - CHECK, s[i] == level_o[i]: bounce rejected; return to STABLE, cnt=0, no event.
  - CHECK, s[i] != level_o[i] and cnt == DebounceCycles-1: toggle level_o[i], set pend[i]=1, set edge[i]=new level, go to STABLE.
  - CHECK, otherwise: cnt++.
- Latency: for a clean transition, level_o[i] updates on the (DebounceCycles+2)th rising edge, counting the edge that first samples the new pin value as the 1st.
- Pending overwrite: if a channel toggles while pend[i] is still 1:
  - edge[i] takes the new value;
  - overflow_o is set.
- Arbiter (fixed priority, lowest index wins):
  - Each cycle, if the FIFO is not full at cycle start, push {i, edge[i]} for the lowest i with pend[i]=1 and clear pend[i].
  - At most one push per cycle.
  - If channel i toggles on the same edge its pending event is pushed, the old event is pushed and pend[i] stays 1 with the new edge. No overflow is flagged in this case.
- FIFO:
  - Registered storage.
  - event_valid_o = !empty. event_id_o and event_rise_o show the head entry.
  - Pop on event_valid_o & event_ready_i.
  - Full is evaluated before the pop: a full FIFO does not accept a push in the same cycle as a pop. The pending bit simply waits.
  - Push and pop in the same non-full cycle are both performed.
  - Pointers wrap modulo FifoDepth.
  - Head outputs hold stable while valid and not ready.
- overflow_o:
  - Set on a pending overwrite.
  - Cleared by overflow_clr_i.
  - Set wins over clear in the same cycle.
  - No other effect on datapath.

Test Plan:
- Bench parameters: DebounceCycles=8, NumIn=3, FifoDepth=4.
- Reset behaviour: assert rst_ni=0 mid-count on ch0 -> all outputs 0 immediately; no event after release while pin_i=0.
- Clean press: pin_i[0] 0->1 held -> level_o[0]=1 on the 10th edge; one event {id=0, rise=1}. Release -> later {id=0, rise=0}.
- Bounce rejection: pin_i[1] toggles 1 for 5 cycles, back to 0 -> level_o unchanged, event_valid_o stays 0, overflow_o=0.
- Simultaneous: pin_i 000->111 in one cycle -> events popped in order id 0, 1, 2 on consecutive cycles with event_ready_i=1; all rise=1.
- Backpressure/full: event_ready_i=0, generate 5 rise/fall events on ch0/ch1 -> FIFO holds 4; 5th stays pending, no loss. Toggle that channel again -> overflow_o=1. Pulse overflow_clr_i -> 0. Drain -> FIFO order preserved.
- Clear/set race: overflow_clr_i asserted on the same cycle as an overwrite -> overflow_o remains 1.
